turn_signal_ctrl: RTL and testbench
===================================

Name: turn_signal_ctrl

Overview:
- Upstream control stage for the left/right taillight sequencers.
- Synchronizes and debounces raw slide-switch inputs (left, right, hazard, brake) and arbitrates them in a 4-state mode FSM.
- Drives the per-side active-high sequencer holds, solid brake-light enables, and a conflict flag.
- Runs on the undivided board clock; its hold outputs feed the sequencers' asynchronous `rst` inputs directly.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a synced input is accepted (10 ms at 100 MHz); must be >= 1.
- TIMEOUT_CYCLES, 3000000000, auto-cancel limit in cycles (30 s at 100 MHz); used only when TURN_AUTOCANCEL_EN is defined.

Ports:
- clk  input  1  system clock (100 MHz board clock)
- rst  input  1  asynchronous, active-high reset
- sw_left  input  1  raw left-turn switch, asynchronous to clk
- sw_right  input  1  raw right-turn switch, asynchronous to clk
- sw_hazard  input  1  raw hazard switch, asynchronous to clk
- sw_brake  input  1  raw brake switch, asynchronous to clk
- seq_rst_left  output  1  high = hold left sequencer in reset
- seq_rst_right  output  1  high = hold right sequencer in reset
- brake_left  output  1  solid brake light, left side
- brake_right  output  1  solid brake light, right side
- mode  output  2  current FSM state: 00 IDLE, 01 LEFT, 10 RIGHT, 11 HAZARD
- err_conflict  output  1  left and right both requested without hazard

Behaviour:
- Reset: all flops clear asynchronously.
  - Sync and debounced values = 0, counters = 0, mode = IDLE.
  - seq_rst_left = seq_rst_right = 1; brake_left = brake_right = 0; err_conflict = 0.
- Synchronizer: 2-flop chain per switch.
- Debounce: one counter per input, width $clog2(DEBOUNCE_CYCLES+1).
  - If synced value == debounced value, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES, the debounced value toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is never accepted.
  - Latency from raw edge to debounced edge: 2 + DEBOUNCE_CYCLES cycles.
- Requested mode, from debounced inputs, in priority order:
  - hazard -> HAZARD
  - left & right -> IDLE, with err_conflict = 1
  - left only -> LEFT
  - right only -> RIGHT
  - none -> IDLE
- FSM transitions:
  - Current == requested: hold.
  - IDLE -> any requested non-IDLE mode: next cycle.
  - Any non-IDLE -> different non-IDLE mode: pass through IDLE for exactly one cycle, so both sequencers restart from their first pattern.
  - Any non-IDLE -> IDLE: next cycle.
  - On entry to HAZARD, both holds deassert in the same cycle so the two sides stay in phase.
- Outputs are all registered, updating one cycle after the FSM state (per-input lag is set by the debounce latency above).
  - seq_rst_left = 0 only in LEFT or HAZARD.
  - seq_rst_right = 0 only in RIGHT or HAZARD.
  - brake_left = brake_db & (mode not LEFT and not HAZARD).
  - brake_right = brake_db & (mode not RIGHT and not HAZARD).
  - So the turning side keeps sequencing under brake; in hazard, brake has no effect.
  - err_conflict is registered from the arbitration term above.
- Reset mid-operation: immediate return to the reset values, independent of clk.

Optional Feature:
- Macro: TURN_AUTOCANCEL_EN.
- Defined:
  - A run counter counts cycles spent in LEFT or RIGHT; HAZARD is excluded.
  - When the counter reaches TIMEOUT_CYCLES, the FSM goes to IDLE and sets a latched cancel bit.
  - While the cancel bit is set, LEFT and RIGHT requests are treated as none.
  - The cancel bit clears when the debounced left and right are both 0.
  - Hazard overrides the cancel bit.
  - The counter clears on any state change.
- Undefined: no counter, no cancel bit; turns persist indefinitely. TIMEOUT_CYCLES is unused.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20):
- Reset released with all switches 0 -> seq_rst_left = seq_rst_right = 1, mode = 00, brake_* = 0, err_conflict = 0 for 50 cycles.
- sw_left pulse of 3 cycles -> never accepted, mode stays 00. sw_left held -> mode = 01 within 2+4+1 cycles, seq_rst_left = 0 one cycle later, seq_rst_right = 1.
- From LEFT, sw_left=0 and sw_right=1 together -> mode sequence 01, 00 (exactly 1 cycle), 10; the holds never deassert simultaneously.
- sw_hazard=1 while sw_brake=1 -> mode = 11, both holds fall in the same cycle, brake_left = brake_right = 0. Hazard off -> both brakes return to 1.
- sw_left = sw_right = 1, hazard 0 -> mode = 00, err_conflict = 1. Drop sw_right -> err_conflict = 0 and mode = 01 after debounce.
- TURN_AUTOCANCEL_EN defined, sw_right held -> mode returns to 00 after 20 cycles in RIGHT and stays there. Release and re-press sw_right -> RIGHT again. Undefined build: RIGHT holds for 100 cycles.

Source files
------------

// File: rtl/turn_signal_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : turn_signal_ctrl
// Purpose  : Syncs/debounces the turn, hazard and brake switches, then arbitrates
//            the turn mode. Defining TURN_AUTOCANCEL_EN adds a turn auto-cancel timeout.
// Revision : 1.0 - initial release
// ============================================================================
module turn_signal_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned TIMEOUT_CYCLES  = 32'd3000000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_left,
    input  logic       sw_right,
    input  logic       sw_hazard,
    input  logic       sw_brake,
    output logic       seq_rst_left,
    output logic       seq_rst_right,
    output logic       brake_left,
    output logic       brake_right,
    output logic [1:0] mode,
    output logic       err_conflict
);

    localparam int c_L = 0;
    localparam int c_R = 1;
    localparam int c_H = 2;
    localparam int c_B = 3;
    localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("turn_signal_ctrl: DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LEFT   = 2'b01,
        ST_RIGHT  = 2'b10,
        ST_HAZARD = 2'b11
    } state_t;

    logic [3:0]        w_sw;
    logic [3:0]        r_sync1;
    logic [3:0]        r_sync2;
    logic [3:0]        r_db;
    logic [c_DB_W-1:0] r_cnt [4];
    state_t            r_state;
    state_t            w_state_nxt;
    state_t            w_req;
    logic              w_left_req;
    logic              w_right_req;
    logic              w_conflict;
    logic              w_timeout;

    assign w_sw = {sw_brake, sw_hazard, sw_right, sw_left};

    // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_sw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == c_DB_LAST) begin
                    r_db[i]  <= ~r_db[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef TURN_AUTOCANCEL_EN
    localparam int c_RUN_W = $clog2(64'(TIMEOUT_CYCLES) + 64'd1);
    localparam logic [c_RUN_W-1:0] c_RUN_LAST = c_RUN_W'(TIMEOUT_CYCLES - 1);

    logic [c_RUN_W-1:0] r_run_cnt;
    logic               r_cancel;

    assign w_timeout   = ((r_state == ST_LEFT) || (r_state == ST_RIGHT)) && (r_run_cnt == c_RUN_LAST);
    assign w_left_req  = r_db[c_L] & ~r_cancel;
    assign w_right_req = r_db[c_R] & ~r_cancel;

    // Cancel stays latched until both turn switches are released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_cnt <= '0;
            r_cancel  <= 1'b0;
        end else begin
            if ((w_state_nxt != r_state) || !((r_state == ST_LEFT) || (r_state == ST_RIGHT))) begin
                r_run_cnt <= '0;
            end else begin
                r_run_cnt <= r_run_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_cancel <= 1'b1;
            end else if (!r_db[c_L] && !r_db[c_R]) begin
                r_cancel <= 1'b0;
            end
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign w_left_req  = r_db[c_L];
    assign w_right_req = r_db[c_R];
`endif

    assign w_conflict = r_db[c_L] & r_db[c_R] & ~r_db[c_H];

    always_comb begin
        w_req = ST_IDLE;
        if (r_db[c_H]) begin
            w_req = ST_HAZARD;
        end else if (w_left_req && w_right_req) begin
            w_req = ST_IDLE;
        end else if (w_left_req) begin
            w_req = ST_LEFT;
        end else if (w_right_req) begin
            w_req = ST_RIGHT;
        end
    end

    // Moving between two active modes detours through IDLE so both sequencers restart.
    always_comb begin
        w_state_nxt = r_state;
        if (w_timeout) begin
            w_state_nxt = ST_IDLE;
        end else if (w_req != r_state) begin
            w_state_nxt = (r_state == ST_IDLE) ? w_req : ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_rst_left  <= 1'b1;
            seq_rst_right <= 1'b1;
            brake_left    <= 1'b0;
            brake_right   <= 1'b0;
            err_conflict  <= 1'b0;
        end else begin
            seq_rst_left  <= !((r_state == ST_LEFT) || (r_state == ST_HAZARD));
            seq_rst_right <= !((r_state == ST_RIGHT) || (r_state == ST_HAZARD));
            brake_left    <= r_db[c_B] && !((r_state == ST_LEFT) || (r_state == ST_HAZARD));
            brake_right   <= r_db[c_B] && !((r_state == ST_RIGHT) || (r_state == ST_HAZARD));
            err_conflict  <= w_conflict;
        end
    end

    assign mode = r_state;

endmodule
`default_nettype wire

// File: tb/tb_turn_signal_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_turn_signal_ctrl
// Purpose  : Directed and randomized checking of turn_signal_ctrl against a
//            cycle-level behavioural model of the switch/mode rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_turn_signal_ctrl;

    localparam int unsigned DB = 4;
    localparam int unsigned TO = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] raw;   // {brake, hazard, right, left}
    logic       seq_rst_left, seq_rst_right, brake_left, brake_right, err_conflict;
    logic [1:0] mode;

    int n_vec = 0;
    int n_err = 0;

    // Model: synced samples, sample history, accepted levels, mode 0..3, registered outputs.
    bit [3:0]  m_s1, m_s2, m_db;
    bit [31:0] m_hist [4];
    int        m_mode;
    bit        m_hl, m_hr, m_bl, m_br, m_cf;
    int        m_tcnt;
    bit        m_cancel;

    always #5 clk = ~clk;

    turn_signal_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .TIMEOUT_CYCLES  (TO)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .sw_left       (raw[0]),
        .sw_right      (raw[1]),
        .sw_hazard     (raw[2]),
        .sw_brake      (raw[3]),
        .seq_rst_left  (seq_rst_left),
        .seq_rst_right (seq_rst_right),
        .brake_left    (brake_left),
        .brake_right   (brake_right),
        .mode          (mode),
        .err_conflict  (err_conflict)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0;
        for (int i = 0; i < 4; i++) m_hist[i] = '0;
        m_mode = 0;
        m_hl = 1'b1; m_hr = 1'b1; m_bl = 1'b0; m_br = 1'b0; m_cf = 1'b0;
        m_tcnt = 0; m_cancel = 1'b0;
    endtask

    task automatic model_edge();
        bit [3:0]  db_new;
        bit [31:0] mask;
        bit        lreq, rreq, tmo;
        int        req, nxt;
        if (rst) begin
            model_reset();
            return;
        end
        // A level flips once DB consecutive synced samples all disagree with it.
        mask = (32'd1 << (DB - 1)) - 32'd1;
        db_new = m_db;
        for (int i = 0; i < 4; i++) begin
            if ((m_s2[i] != m_db[i]) && (((m_hist[i] ^ {32{m_db[i]}}) & mask) == mask))
                db_new[i] = ~m_db[i];
            m_hist[i] = {m_hist[i][30:0], m_s2[i]};
        end
        lreq = m_db[0] && !m_cancel;
        rreq = m_db[1] && !m_cancel;
        if (m_db[2])            req = 3;
        else if (lreq && rreq)  req = 0;
        else if (lreq)          req = 1;
        else if (rreq)          req = 2;
        else                    req = 0;
        tmo = 1'b0;
`ifdef TURN_AUTOCANCEL_EN
        tmo = ((m_mode == 1) || (m_mode == 2)) && (m_tcnt == int'(TO) - 1);
`endif
        if (tmo)                nxt = 0;
        else if (req == m_mode) nxt = m_mode;
        else if (m_mode == 0)   nxt = req;
        else                    nxt = 0;
        m_hl = !((m_mode == 1) || (m_mode == 3));
        m_hr = !((m_mode == 2) || (m_mode == 3));
        m_bl = m_db[3] && !((m_mode == 1) || (m_mode == 3));
        m_br = m_db[3] && !((m_mode == 2) || (m_mode == 3));
        m_cf = m_db[0] && m_db[1] && !m_db[2];
`ifdef TURN_AUTOCANCEL_EN
        m_tcnt = ((nxt == m_mode) && ((m_mode == 1) || (m_mode == 2))) ? m_tcnt + 1 : 0;
        if (tmo) m_cancel = 1'b1;
        else if (!m_db[0] && !m_db[1]) m_cancel = 1'b0;
`endif
        m_mode = nxt;
        m_db   = db_new;
        m_s2   = m_s1;
        m_s1   = raw;
    endtask

    task automatic check_all();
        chk("mode",          32'(mode),          32'(m_mode));
        chk("seq_rst_left",  32'(seq_rst_left),  32'(m_hl));
        chk("seq_rst_right", 32'(seq_rst_right), 32'(m_hr));
        chk("brake_left",    32'(brake_left),    32'(m_bl));
        chk("brake_right",   32'(brake_right),   32'(m_br));
        chk("err_conflict",  32'(err_conflict),  32'(m_cf));
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic wait_mode(input logic [1:0] target, input int budget, output int cycles);
        cycles = 0;
        while ((mode !== target) && (cycles < budget)) begin
            step(1);
            cycles++;
        end
    endtask

    initial begin
        int cyc, idle_n, both_low;
        rst = 1'b1;
        raw = 4'b0000;
        model_reset();
        step(2);
        rst = 1'b0;

        // Idle after reset
        step(50);
        chk("reset_mode", 32'(mode), 32'd0);
        chk("reset_holds", 32'({seq_rst_left, seq_rst_right}), 32'd3);
        chk("reset_brk_err", 32'({brake_left, brake_right, err_conflict}), 32'd0);

        // Short glitch rejected, held switch accepted after 2+DB+1 cycles
        raw = 4'b0001; step(3);
        raw = 4'b0000; step(12);
        chk("glitch_mode", 32'(mode), 32'd0);
        raw = 4'b0001;
        wait_mode(2'b01, 20, cyc);
        chk("left_latency", 32'(cyc), 32'd7);
        step(1);
        chk("left_holds", 32'({seq_rst_left, seq_rst_right}), 32'd1);

        // LEFT -> RIGHT goes through one IDLE cycle, holds never both low
        raw = 4'b0010;
        idle_n = 0; both_low = 0;
        for (int k = 0; k < 14; k++) begin
            step(1);
            if (mode == 2'b00) idle_n++;
            if (!seq_rst_left && !seq_rst_right) both_low++;
        end
        chk("pass_idle_len", 32'(idle_n), 32'd1);
        chk("pass_both_low", 32'(both_low), 32'd0);
        chk("pass_mode", 32'(mode), 32'd2);

        // Hazard under brake
        raw = 4'b0000; step(10);
        raw = 4'b1000; step(10);
        chk("brake_idle", 32'({brake_left, brake_right}), 32'd3);
        raw = 4'b1100;
        wait_mode(2'b11, 20, cyc);
        chk("hazard_latency", 32'(cyc), 32'd7);
        step(1);
        chk("hazard_holds", 32'({seq_rst_left, seq_rst_right}), 32'd0);
        chk("hazard_brakes", 32'({brake_left, brake_right}), 32'd0);
        raw = 4'b1000; step(10);
        chk("hazard_off_brakes", 32'({brake_left, brake_right}), 32'd3);

        // Conflict
        raw = 4'b0011; step(10);
        chk("conflict_mode", 32'(mode), 32'd0);
        chk("conflict_err", 32'(err_conflict), 32'd1);
        raw = 4'b0001; step(10);
        chk("conflict_clear_err", 32'(err_conflict), 32'd0);
        chk("conflict_clear_mode", 32'(mode), 32'd1);

        // Long RIGHT: auto-cancel or persistence
        raw = 4'b0000; step(10);
        raw = 4'b0010;
        wait_mode(2'b10, 20, cyc);
        chk("right_latency", 32'(cyc), 32'd7);
`ifdef TURN_AUTOCANCEL_EN
        step(25);
        chk("autocancel_mode", 32'(mode), 32'd0);
        step(20);
        chk("autocancel_stays", 32'(mode), 32'd0);
        raw = 4'b0000; step(10);
        raw = 4'b0010; step(10);
        chk("autocancel_repress", 32'(mode), 32'd2);
`else
        step(100);
        chk("right_persist", 32'(mode), 32'd2);
`endif

        // Asynchronous reset mid-operation
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        step(1);
        rst = 1'b0;

        // Randomized segments with occasional async reset
        for (int s = 0; s < 200; s++) begin
            raw = 4'($urandom_range(0, 15));
            step(int'($urandom_range(1, 12)));
            if ($urandom_range(0, 39) == 0) begin
                #2 rst = 1'b1;
                #1 model_reset();
                check_all();
                step(1);
                rst = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
